dmem_port: RTL and testbench

//   Data-memory responder for the control decoder's load/memwrite/storeops outputs. It turns a

---
 rtl/dmem_port_pkg.sv | 64 ++++++
 rtl/dmem_load_ext.sv | 39 +++
 rtl/dmem_port.sv | 173 +++++++++++++++++
 tb/tb_dmem_port.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_pkg.sv
// ==================================================================
// dmem_port_pkg : shared encodings and lane helpers for dmem_port
// Rev 1.0
// ==================================================================
`default_nettype none

package dmem_port_pkg;

   localparam logic [1:0] DMEM_IDLE = 2'd0;
   localparam logic [1:0] DMEM_BUS  = 2'd1;
   localparam logic [1:0] DMEM_DONE = 2'd2;
   localparam logic [1:0] DMEM_ERR  = 2'd3;

   localparam logic [1:0] STORE_NONE = 2'd0;
   localparam logic [1:0] STORE_B    = 2'd1;
   localparam logic [1:0] STORE_H    = 2'd2;
   localparam logic [1:0] STORE_W    = 2'd3;

   localparam logic [2:0] FUNCT_LB  = 3'b000;
   localparam logic [2:0] FUNCT_LH  = 3'b001;
   localparam logic [2:0] FUNCT_LW  = 3'b010;
   localparam logic [2:0] FUNCT_LBU = 3'b100;
   localparam logic [2:0] FUNCT_LHU = 3'b101;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   function automatic logic [1:0] store_size(input logic [1:0] sops);
      case (sops)
         STORE_B: store_size = SIZE_B;
         STORE_H: store_size = SIZE_H;
         default: store_size = SIZE_W;
      endcase
   endfunction

   // Unknown load functs fall through to word size so they fetch the raw word.
   function automatic logic [1:0] load_size(input logic [2:0] funct);
      case (funct[1:0])
         2'b00:   load_size = SIZE_B;
         2'b01:   load_size = SIZE_H;
         default: load_size = SIZE_W;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  lane_be = 4'b0001 << off;
         SIZE_H:  lane_be = off[1] ? 4'b1100 : 4'b0011;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_B:  lane_wdata = {4{data[7:0]}};
         SIZE_H:  lane_wdata = {2{data[15:0]}};
         default: lane_wdata = data;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_load_ext.sv
// ==================================================================
// dmem_load_ext : byte/half select and sign/zero extension of a read word
// Rev 1.0
// ==================================================================
`default_nettype none

module dmem_load_ext
   import dmem_port_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct)
         FUNCT_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         FUNCT_LBU: result = {24'h000000, byte_sel};
         FUNCT_LH:  result = {{16{half_sel[15]}}, half_sel};
         FUNCT_LHU: result = {16'h0000, half_sel};
         default:   result = word;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_port.sv
// ==================================================================
// dmem_port : core load/store to valid/ready word-bus responder with stall
// Rev 1.0
// ==================================================================
`default_nettype none

module dmem_port
   import dmem_port_pkg::*;
#(
   parameter int TIMEOUT_CYC = 0
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        memwrite,
   input  logic [1:0]  storeops,
   input  logic [2:0]  load_funct,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        bus_err,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   logic [1:0]       state_q,     state_d;
   logic             bus_valid_q, bus_valid_d;
   logic             bus_we_q,    bus_we_d;
   logic [31:0]      bus_addr_q,  bus_addr_d;
   logic [3:0]       bus_be_q,    bus_be_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;
   logic [31:0]      rdata_q,     rdata_d;
   logic [1:0]       off_q,       off_d;
   logic [2:0]       funct_q,     funct_d;
   logic             to_err_q,    to_err_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic        is_store;
   logic        is_load;
   logic        req;
   logic [1:0]  req_size;
   logic        req_misaligned;
   logic [31:0] ext_data;

   assign is_store = memwrite && (storeops != STORE_NONE);
   assign is_load  = load && !is_store;
   assign req      = is_store || is_load;
   assign req_size = is_store ? store_size(storeops) : load_size(load_funct);
   assign req_misaligned = ((req_size == SIZE_H) && addr[0]) ||
                           ((req_size == SIZE_W) && (addr[1:0] != 2'b00));

   dmem_load_ext u_load_ext (
      .word   (bus_rdata),
      .offset (off_q),
      .funct  (funct_q),
      .result (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DMEM_IDLE;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
         off_q       <= '0;
         funct_q     <= '0;
         to_err_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         bus_valid_q <= bus_valid_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         off_q       <= off_d;
         funct_q     <= funct_d;
         to_err_q    <= to_err_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bus_valid_d = bus_valid_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      off_d       = off_q;
      funct_d     = funct_q;
      to_err_d    = to_err_q;
      cnt_d       = cnt_q;

      case (state_q)
         DMEM_IDLE: begin
            cnt_d    = '0;
            to_err_d = 1'b0;
            if (req) begin
               if (req_misaligned) begin
                  state_d = DMEM_ERR;
               end else begin
                  state_d     = DMEM_BUS;
                  bus_valid_d = 1'b1;
                  bus_we_d    = is_store;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = lane_be(req_size, addr[1:0]);
                  bus_wdata_d = lane_wdata(req_size, wdata);
                  off_d       = addr[1:0];
                  funct_d     = is_store ? FUNCT_LW : load_funct;
               end
            end
         end
         DMEM_BUS: begin
            // A ready in the final allowed cycle still completes the transfer.
            if (bus_ready) begin
               rdata_d     = ext_data;
               bus_valid_d = 1'b0;
               state_d     = DMEM_DONE;
            end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
               bus_valid_d = 1'b0;
               to_err_d    = 1'b1;
               state_d     = DMEM_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = DMEM_IDLE;
         end
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
      case (state_q)
         DMEM_IDLE: stall = req && rst_n;
         DMEM_BUS:  stall = 1'b1;
         DMEM_ERR: begin
            misalign = !to_err_q;
            bus_err  = to_err_q;
         end
         default: ;
      endcase
   end

   assign rdata     = rdata_q;
   assign bus_valid = bus_valid_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port.sv
// ==================================================================
// tb_dmem_port : directed vector bench for dmem_port (TIMEOUT_CYC = 4)
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_dmem_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        memwrite = 1'b0;
   logic [1:0]  storeops = 2'd0;
   logic [2:0]  load_funct = 3'd0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall;
   logic [31:0] rdata;
   logic        misalign;
   logic        bus_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   always #5 clk = ~clk;

   dmem_port #(.TIMEOUT_CYC(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .memwrite   (memwrite),
      .storeops   (storeops),
      .load_funct (load_funct),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .rdata      (rdata),
      .misalign   (misalign),
      .bus_err    (bus_err),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .bus_rdata  (bus_rdata)
   );

   // rdy: bus cycle (1-based) on which ready is given; 0 = never (times out after 4).
   typedef struct {
      logic        mw;
      logic        ld;
      logic [1:0]  sops;
      logic [2:0]  fn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brd;
      int          rdy;
      logic        chk_bus;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_we;
      logic        chk_rd;
      logic [31:0] e_rd;
      logic        e_mis;
      logic        e_berr;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   ncyc;
      int   nval;
      int   exp_val;
      logic seen;
      logic done;
      @(posedge clk); #1;
      load       = v.ld;
      memwrite   = v.mw;
      storeops   = v.sops;
      load_funct = v.fn;
      addr       = v.addr;
      wdata      = v.wdata;
      bus_rdata  = v.brd;
      bus_ready  = 1'b0;
      ncyc = 0; nval = 0; seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (stall) begin
            ncyc++;
            if (bus_valid) begin
               nval++;
               if (!seen && v.chk_bus) begin
                  seen = 1'b1;
                  chk($sformatf("v%0d bus_addr", idx), bus_addr, v.e_addr);
                  chk($sformatf("v%0d bus_be", idx), {28'h0, bus_be}, {28'h0, v.e_be});
                  chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.e_wdata);
                  chk($sformatf("v%0d bus_we", idx), {31'h0, bus_we}, {31'h0, v.e_we});
               end
               bus_ready = (nval == v.rdy);
            end
         end else begin
            done = 1'b1;
            if (v.chk_rd)
               chk($sformatf("v%0d rdata", idx), rdata, v.e_rd);
            chk($sformatf("v%0d misalign", idx), {31'h0, misalign}, {31'h0, v.e_mis});
            chk($sformatf("v%0d bus_err", idx), {31'h0, bus_err}, {31'h0, v.e_berr});
            load      = 1'b0;
            memwrite  = 1'b0;
            bus_ready = 1'b0;
         end
      end
      chk($sformatf("v%0d completed", idx), {31'h0, done}, 32'd1);
      exp_val = v.e_mis ? 0 : ((v.rdy == 0) ? 4 : v.rdy);
      chk($sformatf("v%0d valid_cycles", idx), nval, exp_val);
      chk($sformatf("v%0d stall_cycles", idx), ncyc, 1 + exp_val);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           mw    ld    sops  fn       addr          wdata         brd           rdy chk   e_addr        e_be   e_wdata       we    chkrd e_rd          mis   berr
      vecs[0]  = '{1'b1, 1'b0, 2'd3, 3'b000, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 1, 1'b1, 32'h00000100, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'd1, 3'b000, 32'h00000103, 32'h000000A5, 32'h00000000, 1, 1'b1, 32'h00000100, 4'h8, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 2'd0, 3'b000, 32'h00000102, 32'h00000000, 32'h1280FF00, 3, 1'b1, 32'h00000100, 4'h4, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 3'b100, 32'h00000102, 32'h00000000, 32'h1280FF00, 2, 1'b1, 32'h00000100, 4'h4, 32'h00000000, 1'b0, 1'b1, 32'h00000080, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 2'd0, 3'b001, 32'h00000101, 32'h00000000, 32'h00000000, 1, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 3'b010, 32'h00000104, 32'h00000000, 32'h00000000, 0, 1'b1, 32'h00000104, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 2'd3, 3'b000, 32'h00000200, 32'h12345678, 32'h00000000, 1, 1'b1, 32'h00000200, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 2'd0, 3'b001, 32'h00000202, 32'h00000000, 32'h80017FFF, 4, 1'b1, 32'h00000200, 4'hC, 32'h00000000, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 3'b101, 32'h00000200, 32'h00000000, 32'h8001F234, 1, 1'b1, 32'h00000200, 4'h3, 32'h00000000, 1'b0, 1'b1, 32'h0000F234, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 3'b010, 32'h00000208, 32'h00000000, 32'hCAFEF00D, 2, 1'b1, 32'h00000208, 4'hF, 32'h00000000, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 2'd2, 3'b000, 32'h0000020A, 32'h0000BEEF, 32'h00000000, 1, 1'b1, 32'h00000208, 4'hC, 32'hBEEFBEEF, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 2'd3, 3'b000, 32'h0000020E, 32'h00000001, 32'h00000000, 1, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 2'd0, 3'b110, 32'h00000300, 32'h00000000, 32'h89ABCDEF, 1, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 1'b0, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 2'd0, 3'b000, 32'h00000101, 32'h00000000, 32'h00007F00, 1, 1'b1, 32'h00000100, 4'h2, 32'h00000000, 1'b0, 1'b1, 32'h0000007F, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 2'd1, 3'b010, 32'h00000401, 32'h0000003C, 32'h00000000, 1, 1'b1, 32'h00000400, 4'h2, 32'h3C3C3C3C, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset bus_valid", {31'h0, bus_valid}, 32'd0);
      chk("reset stall", {31'h0, stall}, 32'd0);
      chk("reset rdata", rdata, 32'h0);
      chk("reset misalign", {31'h0, misalign}, 32'd0);
      chk("reset bus_err", {31'h0, bus_err}, 32'd0);
      chk("reset bus_be", {28'h0, bus_be}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++)
         run_vec(vecs[i], i);

      // memwrite with no store size is not a request
      @(posedge clk); #1;
      memwrite = 1'b1; storeops = 2'd0; addr = 32'h00000100;
      repeat (2) begin
         @(negedge clk);
         chk("nop store stall", {31'h0, stall}, 32'd0);
         chk("nop store bus_valid", {31'h0, bus_valid}, 32'd0);
      end
      memwrite = 1'b0;

      // Reset while a load is outstanding on the bus
      @(posedge clk); #1;
      load = 1'b1; load_funct = 3'b010; addr = 32'h00000500; bus_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst in bus", {31'h0, bus_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst bus_valid", {31'h0, bus_valid}, 32'd0);
      chk("midrst stall", {31'h0, stall}, 32'd0);
      @(posedge clk); #1;
      load = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst stall", {31'h0, stall}, 32'd0);
      chk("postrst bus_valid", {31'h0, bus_valid}, 32'd0);
      run_vec(vecs[0], 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
